// File: rtl/char_pkg.sv
// Shared types and constants for the character glyph fetch path.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package char_pkg;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;
  localparam int CODE_W  = 8;
  localparam int ROW_W   = 4;
  localparam int ROM_AW  = CODE_W + ROW_W;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    LOAD
  } state_t;

  // Map a glyph column to the bit position inside an 8-pixel row.
  function automatic logic [2:0] col_to_bit(input logic [2:0] col, input logic msb_first);
    return msb_first ? (3'd7 - col) : col;
  endfunction

endpackage

// File: rtl/char_glyph_server.sv
// Responder for the character renderer: fetches one glyph row from the font ROM per
// readEn pulse, holds it, and returns the pixel selected by colCnt.
// Latency: readEn at N -> romEn at N+1 -> new row visible from N+2+ROM_LAT; bitDisp is
// combinational from colCnt. Backpressure: none; readEn while busy is dropped and
// latches the sticky overrun flag.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   readEn            one-cycle fetch request; rowCnt/charCode sampled with it
//   colCnt            pixel column, muxed combinationally onto bitDisp
//   romEn/romAddr     one-cycle ROM strobe; address {charCode, rowCnt} held until next fetch
//   romData           ROM row, captured only in the LOAD cycle
//   bitDisp           selected pixel of the active row (0 until a row has been loaded)
//   rowValid          active row holds fetched data; never drops between rows
//   overrun           sticky: a request arrived while a fetch was in progress
module char_glyph_server
  import char_pkg::*;
#(
  parameter int ROM_LAT   = 1,     // 1..4
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               readEn,
  input  logic [ROW_W-1:0]   rowCnt,
  input  logic [2:0]         colCnt,
  input  logic [CODE_W-1:0]  charCode,
  output logic               romEn,
  output logic [ROM_AW-1:0]  romAddr,
  input  logic [GLYPH_W-1:0] romData,
  output logic               bitDisp,
  output logic               rowValid,
  output logic               overrun
);

  // ISSUE already accounts for one ROM cycle, so WAIT lasts ROM_LAT-1 cycles.
  // The down counter is loaded with ROM_LAT-2 and WAIT exits when it reads zero;
  // for ROM_LAT=1 there is no WAIT cycle at all and ISSUE goes straight to LOAD.
  localparam logic [1:0] WAIT_INIT = (ROM_LAT >= 2) ? 2'(ROM_LAT - 2) : 2'd0;

  state_t             state;
  logic [ROM_AW-1:0]  addrReg;
  logic [1:0]         waitCnt;
  logic [GLYPH_W-1:0] activeRow;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addrReg   <= '0;
      romEn     <= 1'b0;
      waitCnt   <= '0;
      activeRow <= '0;
      rowValid  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      romEn <= 1'b0;
      // Any request outside IDLE (including the LOAD cycle) is dropped.
      if (readEn && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (readEn) begin
            addrReg <= {charCode, rowCnt};
            romEn   <= 1'b1;            // high exactly during the ISSUE cycle
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          waitCnt <= WAIT_INIT;
          state   <= (ROM_LAT <= 1) ? LOAD : WAIT;
        end
        WAIT: begin
          if (waitCnt == 2'd0) begin
            state <= LOAD;
          end else begin
            waitCnt <= waitCnt - 2'd1;
          end
        end
        LOAD: begin
          activeRow <= romData;
          rowValid  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // addrReg only changes on an accepted request, so the ROM address holds between fetches.
  assign romAddr = addrReg;
  assign bitDisp = rowValid & activeRow[col_to_bit(colCnt, MSB_FIRST)];

endmodule
